arith_wb_scheduler: RTL and testbench

// Parametrised issue/writeback scheduler for the arithmetic unit. It replaces per-unit

---
 rtl/arith_wb_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_arith_wb_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_wb_scheduler.sv
// rtl/arith_wb_scheduler.sv - issue/writeback slot scheduler for the arithmetic unit
module arith_wb_scheduler #(
    parameter int                     DATA_W    = 64,
    parameter int                     NUM_UNITS = 4,
    parameter int                     UNIT_W    = 2,
    parameter int                     TAG_W     = 4,
    parameter int                     MAX_LAT   = 64,
    parameter logic [NUM_UNITS*7-1:0] LAT_VEC   = {7'd26, 7'd12, 7'd5, 7'd1},
    parameter logic [NUM_UNITS-1:0]   PIPELINED = 4'b1011
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [UNIT_W-1:0]             issue_unit,
    input  logic [TAG_W-1:0]              issue_tag,
    output logic [NUM_UNITS-1:0]          unit_start,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_result,
    output logic                          wb_valid,
    output logic [UNIT_W-1:0]             wb_unit,
    output logic [TAG_W-1:0]              wb_tag,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          busy,
    output logic [6:0]                    inflight,
    output logic                          err_illegal
);

    localparam logic [31:0] NUM_UNITS_U = 32'(NUM_UNITS);

    // Slot k holds the op that reaches the writeback capture point k cycles from now.
    logic [MAX_LAT-1:0] s_valid_q, s_valid_d;
    logic [UNIT_W-1:0]  s_unit_q [MAX_LAT];
    logic [UNIT_W-1:0]  s_unit_d [MAX_LAT];
    logic [TAG_W-1:0]   s_tag_q  [MAX_LAT];
    logic [TAG_W-1:0]   s_tag_d  [MAX_LAT];
    logic [6:0]         inflight_q, inflight_d;

    logic               wb_valid_q;
    logic [UNIT_W-1:0]  wb_unit_q;
    logic [TAG_W-1:0]   wb_tag_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic               err_q;

    logic               legal;
    logic               slot_free;
    logic               unit_free;
    logic               accept;
    logic [6:0]         sel_lat;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [DATA_W-1:0]  retire_data;

    assign legal = ({{(32-UNIT_W){1'b0}}, issue_unit} < NUM_UNITS_U);

    // Latency/occupancy lookup for the requested unit; slot 0 is retiring so it never blocks
    always_comb begin
        sel_lat   = 7'd1;
        unit_busy = '0;
        unit_free = 1'b1;
        slot_free = 1'b1;
        for (int k = 1; k < MAX_LAT; k++) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (s_valid_q[k] && (s_unit_q[k] == UNIT_W'(u))) begin
                    unit_busy[u] = 1'b1;
                end
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (issue_unit == UNIT_W'(u)) begin
                sel_lat   = LAT_VEC[u*7 +: 7];
                unit_free = PIPELINED[u] || !unit_busy[u];
            end
        end
        for (int k = 1; k < MAX_LAT; k++) begin
            if ((int'(sel_lat) == k) && s_valid_q[k]) begin
                slot_free = 1'b0;
            end
        end
    end

    assign issue_ready = !rst && !flush && (!legal || (slot_free && unit_free));
    assign accept      = issue_valid && issue_ready;

    // One-hot start pulse to the target unit on an accepted legal issue
    always_comb begin
        unit_start = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (accept && legal && (issue_unit == UNIT_W'(u))) begin
                unit_start[u] = 1'b1;
            end
        end
    end

    // Shift the slot array down one position and book the new op at its due slot
    always_comb begin
        s_valid_d = {1'b0, s_valid_q[MAX_LAT-1:1]};
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            s_unit_d[k] = s_unit_q[k+1];
            s_tag_d[k]  = s_tag_q[k+1];
        end
        s_unit_d[MAX_LAT-1] = '0;
        s_tag_d[MAX_LAT-1]  = '0;
        if (accept && legal) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (int'(sel_lat) == k + 1) begin
                    s_valid_d[k] = 1'b1;
                    s_unit_d[k]  = issue_unit;
                    s_tag_d[k]   = issue_tag;
                end
            end
        end
        inflight_d = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            inflight_d = inflight_d + 7'(s_valid_d[k]);
        end
    end

    // Select the result of the unit whose op is retiring this cycle
    always_comb begin
        retire_data = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (s_unit_q[0] == UNIT_W'(u)) begin
                retire_data = unit_result[u*DATA_W +: DATA_W];
            end
        end
    end

    // Slot valid bits and occupancy count; rst and flush kill everything in flight
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s_valid_q  <= '0;
            inflight_q <= '0;
        end else begin
            s_valid_q  <= s_valid_d;
            inflight_q <= inflight_d;
        end
    end

    // Slot payload; only meaningful where the matching valid bit is set
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_LAT; k++) begin
            s_unit_q[k] <= s_unit_d[k];
            s_tag_q[k]  <= s_tag_d[k];
        end
    end

    // Writeback capture; payload holds between strobes, a slot due during flush is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_unit_q  <= '0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
        end else if (flush) begin
            wb_valid_q <= 1'b0;
        end else if (s_valid_q[0]) begin
            wb_valid_q <= 1'b1;
            wb_unit_q  <= s_unit_q[0];
            wb_tag_q   <= s_tag_q[0];
            wb_data_q  <= retire_data;
        end else begin
            wb_valid_q <= 1'b0;
        end
    end

    // Illegal-unit pulse, one cycle after the dropped issue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !legal;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_unit     = wb_unit_q;
    assign wb_tag      = wb_tag_q;
    assign wb_data     = wb_data_q;
    assign busy        = |s_valid_q;
    assign inflight    = inflight_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_arith_wb_scheduler.sv
// tb/tb_arith_wb_scheduler.sv - self-checking bench for arith_wb_scheduler
module tb_arith_wb_scheduler;

    localparam int UW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           issue_valid;
    logic           issue_ready;
    logic [UW-1:0]  issue_unit;
    logic [3:0]     issue_tag;
    logic [3:0]     unit_start;
    logic [255:0]   unit_result;
    logic           wb_valid;
    logic [UW-1:0]  wb_unit;
    logic [3:0]     wb_tag;
    logic [63:0]    wb_data;
    logic           busy;
    logic [6:0]     inflight;
    logic           err_illegal;

    arith_wb_scheduler #(.UNIT_W(UW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_unit(issue_unit), .issue_tag(issue_tag),
        .unit_start(unit_start), .unit_result(unit_result),
        .wb_valid(wb_valid), .wb_unit(wb_unit), .wb_tag(wb_tag), .wb_data(wb_data),
        .busy(busy), .inflight(inflight), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight op is a booking for the cycle its result is due.
    typedef struct {
        int due;
        int unit;
        int tag;
    } pend_t;

    pend_t       pq[$];
    int          LAT[4] = '{1, 5, 12, 26};
    bit          PIP[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int          cyc;
    int          n_pass;
    int          n_total;
    bit          cur_ready;
    bit          last_acc;
    bit          exp_wb_valid;
    int          exp_wb_unit;
    int          exp_wb_tag;
    logic [63:0] exp_wb_data;
    bit          exp_err;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", name, obs, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int u;
        bit legal;
        bit ready;
        logic [3:0] exp_start;
        u     = int'(issue_unit);
        legal = (u < 4);
        ready = !rst && !flush;
        if (ready && legal) begin
            foreach (pq[i]) begin
                if (pq[i].due == cyc + LAT[u]) ready = 1'b0;
                if (!PIP[u] && pq[i].unit == u && pq[i].due > cyc) ready = 1'b0;
            end
        end
        cur_ready = ready;
        exp_start = (issue_valid && ready && legal) ? 4'(1 << u) : 4'd0;
        check("issue_ready", 64'(issue_ready), 64'(ready));
        check("unit_start", 64'(unit_start), 64'(exp_start));
        check("wb_valid", 64'(wb_valid), 64'(exp_wb_valid));
        check("wb_unit", 64'(wb_unit), 64'(exp_wb_unit));
        check("wb_tag", 64'(wb_tag), 64'(exp_wb_tag));
        check("wb_data", wb_data, exp_wb_data);
        check("busy", 64'(busy), 64'(pq.size() != 0));
        check("inflight", 64'(inflight), 64'(pq.size()));
        check("err_illegal", 64'(err_illegal), 64'(exp_err));
    endtask

    task automatic model_edge();
        int hit;
        bit acc;
        acc = issue_valid && cur_ready;
        last_acc = acc;
        if (rst || flush) begin
            pq.delete();
            exp_wb_valid = 1'b0;
            exp_err      = 1'b0;
            if (rst) begin
                exp_wb_unit = 0;
                exp_wb_tag  = 0;
                exp_wb_data = '0;
            end
        end else begin
            hit = -1;
            foreach (pq[i]) if (pq[i].due == cyc) hit = i;
            if (hit >= 0) begin
                exp_wb_valid = 1'b1;
                exp_wb_unit  = pq[hit].unit;
                exp_wb_tag   = pq[hit].tag;
                exp_wb_data  = unit_result[pq[hit].unit*64 +: 64];
                pq.delete(hit);
            end else begin
                exp_wb_valid = 1'b0;
            end
            exp_err = acc && (int'(issue_unit) >= 4);
            if (acc && int'(issue_unit) < 4) begin
                pq.push_back('{cyc + LAT[int'(issue_unit)], int'(issue_unit), int'(issue_tag)});
            end
        end
    endtask

    task automatic pre();
        #2;
    endtask

    task automatic post();
        check_cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 8; i++) unit_result[i*32 +: 32] = $urandom;
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        tick();
        rst = 1'b0;
        cyc = 0;
        last_acc = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        cyc = 0;
        rst = 1'b1;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_unit = '0;
        issue_tag = '0;
        unit_result = '0;
        repeat (2) @(posedge clk);
        #1;
        pq.delete();
        exp_wb_valid = 1'b0;
        exp_wb_unit = 0;
        exp_wb_tag = 0;
        exp_wb_data = '0;
        exp_err = 1'b0;

        // reset state
        pre();
        check("rst_ready", 64'(issue_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        post();

        // 1: unit2 latency 12, result captured on its due cycle
        do_reset();
        repeat (10) tick();
        issue_valid = 1'b1; issue_unit = 3'd2; issue_tag = 4'd5;
        pre();
        check("t1_start_c10", 64'(unit_start), 64'(4'b0100));
        post();
        issue_valid = 1'b0;
        pre();
        check("t1_start_c11", 64'(unit_start), 64'(0));
        post();
        repeat (10) tick();
        unit_result[128 +: 64] = 64'hDEAD_BEEF;
        tick();
        pre();
        check("t1_wb_valid", 64'(wb_valid), 64'(1));
        check("t1_wb_tag", 64'(wb_tag), 64'(5));
        check("t1_wb_unit", 64'(wb_unit), 64'(2));
        check("t1_wb_data", wb_data, 64'hDEAD_BEEF);
        post();
        pre();
        check("t1_wb_valid_c24", 64'(wb_valid), 64'(0));
        post();

        // 2: slot collision between unit3 and unit2
        do_reset();
        issue_valid = 1'b1; issue_unit = 3'd3; issue_tag = 4'd1;
        tick();
        issue_valid = 1'b0;
        repeat (13) tick();
        issue_valid = 1'b1; issue_unit = 3'd2; issue_tag = 4'd2;
        pre();
        check("t2_ready_c14", 64'(issue_ready), 64'(0));
        post();
        pre();
        check("t2_ready_c15", 64'(issue_ready), 64'(1));
        post();
        issue_valid = 1'b0;
        repeat (11) tick();
        pre();
        check("t2_wb27_valid", 64'(wb_valid), 64'(1));
        check("t2_wb27_unit", 64'(wb_unit), 64'(3));
        post();
        pre();
        check("t2_wb28_valid", 64'(wb_valid), 64'(1));
        check("t2_wb28_unit", 64'(wb_unit), 64'(2));
        post();

        // 3: back-to-back unit0
        do_reset();
        for (int c = 0; c < 12; c++) begin
            issue_valid = (c < 8);
            issue_unit = 3'd0;
            issue_tag = 4'(c);
            pre();
            check("t3_wb_valid", 64'(wb_valid), 64'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) check("t3_wb_tag", 64'(wb_tag), 64'(c - 2));
            check("t3_inflight_max", 64'(inflight <= 7'd1), 64'(1));
            post();
        end

        // 4: non-pipelined unit2 blocks until its result returns
        do_reset();
        issue_valid = 1'b1; issue_unit = 3'd2; issue_tag = 4'd3;
        tick();
        issue_tag = 4'd4;
        for (int c = 1; c <= 12; c++) begin
            pre();
            check("t4_ready", 64'(issue_ready), 64'(c == 12));
            post();
        end
        issue_valid = 1'b0;
        for (int c = 13; c <= 26; c++) begin
            pre();
            check("t4_wb_valid", 64'(wb_valid), 64'(c == 13 || c == 25));
            post();
        end

        // 5: flush, then rst, with three ops in flight
        for (int kind = 0; kind < 2; kind++) begin
            do_reset();
            issue_valid = 1'b1; issue_unit = 3'd3; issue_tag = 4'd1; tick();
            issue_unit = 3'd2; issue_tag = 4'd2; tick();
            issue_unit = 3'd1; issue_tag = 4'd3; tick();
            issue_valid = 1'b0;
            repeat (2) tick();
            issue_valid = 1'b1; issue_unit = 3'd0; issue_tag = 4'd9;
            if (kind == 0) flush = 1'b1; else rst = 1'b1;
            pre();
            check("t5_ready_c5", 64'(issue_ready), 64'(0));
            check("t5_busy_c5", 64'(busy), 64'(1));
            post();
            flush = 1'b0; rst = 1'b0; issue_valid = 1'b0;
            pre();
            check("t5_busy_c6", 64'(busy), 64'(0));
            check("t5_inflight_c6", 64'(inflight), 64'(0));
            post();
            for (int c = 7; c <= 30; c++) begin
                pre();
                check("t5_no_wb", 64'(wb_valid), 64'(0));
                post();
            end
        end

        // 6: illegal unit is accepted and dropped
        do_reset();
        issue_valid = 1'b1; issue_unit = 3'd3; issue_tag = 4'd7;
        tick();
        issue_unit = 3'd5; issue_tag = 4'd2;
        pre();
        check("t6_ready", 64'(issue_ready), 64'(1));
        check("t6_start", 64'(unit_start), 64'(0));
        post();
        issue_valid = 1'b0;
        pre();
        check("t6_err", 64'(err_illegal), 64'(1));
        check("t6_inflight", 64'(inflight), 64'(1));
        post();
        pre();
        check("t6_err_clear", 64'(err_illegal), 64'(0));
        post();

        // randomized traffic against the booking model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (!(issue_valid && !last_acc)) begin
                int r;
                r = int'($urandom_range(0, 19));
                issue_valid = ($urandom_range(0, 9) < 6);
                issue_unit = (r < 18) ? 3'(r % 4) : 3'(4 + r % 4);
                issue_tag = 4'($urandom);
            end
            flush = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush = 1'b0;
        issue_valid = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
